two_source_bus_arbiter: RTL and testbench
=========================================

TWO_SOURCE_BUS_ARBITER -- requirements
Module: two_source_bus_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8: maximum consecutive grant cycles before forced hand-over when the other side requests; legal range 2..255.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_a  input  1  requester A wants the shared 4-bit bus.
REQ-005 req_b  input  1  requester B wants the shared 4-bit bus.
REQ-006 data_a  input  4  requester A data.
REQ-007 data_b  input  4  requester B data.
REQ-008 gnt_a  output  1  A owns the bus (registered).
REQ-009 gnt_b  output  1  B owns the bus (registered).
REQ-010 sel  output  1  select to the 4-bit 2:1 mux datapath; 0 = A, 1 = B (registered).
REQ-011 bus_y  output  4  shared bus; always equals sel ? data_b : data_a (combinational, 4-bit 2:1 mux datapath).
REQ-012 bus_valid  output  1  gnt_a | gnt_b.

Function
REQ-013 FSM states IDLE, GRANT_A, GRANT_B; gnt_a=1 only in GRANT_A, gnt_b=1 only in GRANT_B; never both high.
REQ-014 Round-robin: a last_b flag records the last side granted; on a simultaneous request the side not last served wins.
REQ-015 IDLE: req_a only -> GRANT_A; req_b only -> GRANT_B; both -> per REQ-014; neither -> stay IDLE.
REQ-016 Grant latency: a request sampled high at edge n in IDLE gives gnt high after edge n (visible in cycle n+1), i.e. 1 cycle.
REQ-017 GRANT_X with req_X low: if other side requests, switch directly to the other grant state (no IDLE bubble); else -> IDLE.
REQ-018 hold_cnt counts cycles in the current grant state, cleared on every state entry, saturates at MAX_HOLD-1.
REQ-019 Forced hand-over: in GRANT_X with req_X high, other side requesting and hold_cnt == MAX_HOLD-1 -> switch to the other grant state on that edge.
REQ-020 With other side idle, GRANT_X persists indefinitely while req_X high (hold_cnt saturates, no release).
REQ-021 sel updates on the same edge as the grant: 0 in GRANT_A, 1 in GRANT_B, retains last value in IDLE.
REQ-022 last_b set to 1 on entry to GRANT_B, 0 on entry to GRANT_A; unchanged in IDLE.
REQ-023 Requester deasserting and reasserting in the same cycle as a switch is ignored until the next evaluation; no glitch grants.

Reset
REQ-024 rst_n low asynchronously forces: state IDLE, gnt_a=0, gnt_b=0, sel=0, last_b=1 (A wins first tie), hold_cnt=0, bus_valid=0, stats counters 0.
REQ-025 Reset asserted mid-grant drops the grant immediately (no wait for clock); first grant after release follows REQ-015 from IDLE.
REQ-026 Reset release is synchronized by the user; block needs no internal deassertion logic.

Configuration
REQ-027 Macro ARB_STATS_EN defined: adds outputs cnt_a[7:0], cnt_b[7:0] counting grant-state entries per side, saturating at 255, cleared by reset.
REQ-028 Macro ARB_STATS_EN undefined: cnt_a, cnt_b ports and counters absent; all other behaviour identical.

Verification
REQ-029 Reset then req_a=1, data_a=4'h5 -> next cycle gnt_a=1, sel=0, bus_y=4'h5, bus_valid=1.
REQ-030 From IDLE after reset, req_a=req_b=1 same edge -> GRANT_A first; drop req_a -> next cycle gnt_b=1, sel=1, no IDLE cycle.
REQ-031 MAX_HOLD=8, req_a held high, req_b raised 1 cycle after gnt_a -> gnt_a high exactly 8 cycles then gnt_b=1.
REQ-032 req_b alone held high 300 cycles -> gnt_b stays 1 throughout, hold_cnt saturated, no release.
REQ-033 rst_n pulled low mid-GRANT_B between clock edges -> gnt_b=0, sel=0, bus_valid=0 immediately.
REQ-034 ARB_STATS_EN defined, 260 alternating A/B grants -> cnt_a=cnt_b=130; 600 A entries -> cnt_a=255 saturated.

Source files
------------

// File: rtl/two_source_bus_arbiter.sv
// ----------------------------------------------------------------------------
// two_source_bus_arbiter
//
// Round-robin arbiter that gives two requesters turns on a shared 4-bit bus.
// A grant is held while its owner keeps requesting. When the other side is
// also waiting, the owner is forced to hand over after MAX_HOLD consecutive
// grant cycles. A requester that drops its request hands the bus straight to
// a waiting peer, with no idle cycle in between.
//
// Parameters
//   MAX_HOLD   maximum consecutive grant cycles while the peer waits (2..255)
//
// Optional feature
//   ARB_STATS_EN  when defined, adds cnt_a/cnt_b: saturating 8-bit counts of
//                 grant-state entries per side, cleared by reset.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   req_a      requester A wants the bus
//   req_b      requester B wants the bus
//   data_a     requester A data
//   data_b     requester B data
//   gnt_a      A owns the bus (registered)
//   gnt_b      B owns the bus (registered)
//   sel        mux select, 0 = A, 1 = B (registered, held while idle)
//   bus_y      shared bus, sel ? data_b : data_a
//   bus_valid  gnt_a | gnt_b
//   cnt_a      (ARB_STATS_EN) grant entries for A
//   cnt_b      (ARB_STATS_EN) grant entries for B
// ----------------------------------------------------------------------------
module two_source_bus_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_a,
    input  logic       req_b,
    input  logic [3:0] data_a,
    input  logic [3:0] data_b,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic       sel,
    output logic [3:0] bus_y,
    output logic       bus_valid
`ifdef ARB_STATS_EN
    ,
    output logic [7:0] cnt_a,
    output logic [7:0] cnt_b
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] hold_cnt;
    logic       last_b;
    logic       enter_a;
    logic       enter_b;

    // Next-state decision. A tie in IDLE goes to the side not served last.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_a && req_b)
                    state_nxt = last_b ? GRANT_A : GRANT_B;
                else if (req_a)
                    state_nxt = GRANT_A;
                else if (req_b)
                    state_nxt = GRANT_B;
            end
            GRANT_A: begin
                if (!req_a)
                    state_nxt = req_b ? GRANT_B : IDLE;
                else if (req_b && (hold_cnt == HOLD_LAST))
                    state_nxt = GRANT_B;
            end
            GRANT_B: begin
                if (!req_b)
                    state_nxt = req_a ? GRANT_A : IDLE;
                else if (req_a && (hold_cnt == HOLD_LAST))
                    state_nxt = GRANT_A;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign enter_a = (state_nxt == GRANT_A) && (state != GRANT_A);
    assign enter_b = (state_nxt == GRANT_B) && (state != GRANT_B);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grants and select are registered from the next state so they change on
    // the same edge as the state itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_a  <= 1'b0;
            gnt_b  <= 1'b0;
            sel    <= 1'b0;
            last_b <= 1'b1;
        end else begin
            gnt_a <= (state_nxt == GRANT_A);
            gnt_b <= (state_nxt == GRANT_B);
            if (state_nxt == GRANT_A) begin
                sel    <= 1'b0;
                last_b <= 1'b0;
            end else if (state_nxt == GRANT_B) begin
                sel    <= 1'b1;
                last_b <= 1'b1;
            end
        end
    end

    // Cycles spent in the current grant; restarts on any state change and
    // parks at MAX_HOLD-1 so an uncontested owner is never released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (state_nxt != state) begin
            hold_cnt <= '0;
        end else if ((state != IDLE) && (hold_cnt != HOLD_LAST)) begin
            hold_cnt <= hold_cnt + 8'd1;
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            if (enter_a && (cnt_a != 8'hFF))
                cnt_a <= cnt_a + 8'd1;
            if (enter_b && (cnt_b != 8'hFF))
                cnt_b <= cnt_b + 8'd1;
        end
    end
`else
    logic unused_entry;
    assign unused_entry = enter_a ^ enter_b;
`endif

    assign bus_y     = sel ? data_b : data_a;
    assign bus_valid = gnt_a | gnt_b;

endmodule

// File: tb/tb_two_source_bus_arbiter.sv
module tb_two_source_bus_arbiter;

    localparam int unsigned MAX_HOLD = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_a;
    logic       req_b;
    logic [3:0] data_a;
    logic [3:0] data_b;
    logic       gnt_a;
    logic       gnt_b;
    logic       sel;
    logic [3:0] bus_y;
    logic       bus_valid;
`ifdef ARB_STATS_EN
    logic [7:0] cnt_a;
    logic [7:0] cnt_b;
`endif

    two_source_bus_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_a     (req_a),
        .req_b     (req_b),
        .data_a    (data_a),
        .data_b    (data_b),
        .gnt_a     (gnt_a),
        .gnt_b     (gnt_b),
        .sel       (sel),
        .bus_y     (bus_y),
        .bus_valid (bus_valid)
`ifdef ARB_STATS_EN
        ,
        .cnt_a     (cnt_a),
        .cnt_b     (cnt_b)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard entry: what the DUT must show after the next rising edge.
    typedef struct {
        logic       ga;
        logic       gb;
        logic       s;
        logic [3:0] y;
        logic       v;
        logic [7:0] ca;
        logic [7:0] cb;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: 0 = idle, 1 = A owns, 2 = B owns.
    int         m_state;
    logic       m_last_b;
    int         m_hold;
    logic       m_sel;
    int         m_ca;
    int         m_cb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state  = 0;
        m_last_b = 1'b1;
        m_hold   = 0;
        m_sel    = 1'b0;
        m_ca     = 0;
        m_cb     = 0;
    endtask

    task automatic model_step(input logic ra, input logic rb, input logic [3:0] da, input logic [3:0] db);
        int   nxt;
        logic own;
        logic peer;
        exp_t e;
        nxt = m_state;
        if (m_state == 0) begin
            if (ra && rb)   nxt = m_last_b ? 1 : 2;
            else if (ra)    nxt = 1;
            else if (rb)    nxt = 2;
        end else begin
            own  = (m_state == 1) ? ra : rb;
            peer = (m_state == 1) ? rb : ra;
            if (!own)
                nxt = peer ? 3 - m_state : 0;
            else if (peer && m_hold == MAX_HOLD - 1)
                nxt = 3 - m_state;
        end
        if (nxt != m_state) begin
            m_hold = 0;
            if (nxt == 1 && m_ca < 255) m_ca++;
            if (nxt == 2 && m_cb < 255) m_cb++;
        end else if (m_state != 0 && m_hold < MAX_HOLD - 1) begin
            m_hold++;
        end
        if (nxt == 1) begin m_sel = 1'b0; m_last_b = 1'b0; end
        if (nxt == 2) begin m_sel = 1'b1; m_last_b = 1'b1; end
        m_state = nxt;
        e.ga = (m_state == 1);
        e.gb = (m_state == 2);
        e.s  = m_sel;
        e.y  = m_sel ? db : da;
        e.v  = (m_state != 0);
        e.ca = 8'(m_ca);
        e.cb = 8'(m_cb);
        sb.push_back(e);
    endtask

    task automatic sb_check();
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL sb_empty observed=0 entries expected=1 entry");
            return;
        end
        e = sb.pop_front();
        chk("gnt_a", 32'(gnt_a), 32'(e.ga));
        chk("gnt_b", 32'(gnt_b), 32'(e.gb));
        chk("sel", 32'(sel), 32'(e.s));
        chk("bus_y", 32'(bus_y), 32'(e.y));
        chk("bus_valid", 32'(bus_valid), 32'(e.v));
`ifdef ARB_STATS_EN
        chk("cnt_a", 32'(cnt_a), 32'(e.ca));
        chk("cnt_b", 32'(cnt_b), 32'(e.cb));
`endif
    endtask

    // One clock: drive, predict, clock, compare.
    task automatic cycle(input logic ra, input logic rb, input logic [3:0] da, input logic [3:0] db);
        req_a  = ra;
        req_b  = rb;
        data_a = da;
        data_b = db;
        model_step(ra, rb, da, db);
        @(posedge clk);
        #1;
        sb_check();
    endtask

    task automatic cyc(input logic ra, input logic rb);
        cycle(ra, rb, 4'($urandom), 4'($urandom));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_gnt_a", 32'(gnt_a), 0);
        chk("rst_gnt_b", 32'(gnt_b), 0);
        chk("rst_sel", 32'(sel), 0);
        chk("rst_valid", 32'(bus_valid), 0);
        chk("rst_bus_y", 32'(bus_y), 32'(data_a));
`ifdef ARB_STATS_EN
        chk("rst_cnt_a", 32'(cnt_a), 0);
        chk("rst_cnt_b", 32'(cnt_b), 0);
`endif
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int run_len;
    int drops;

    initial begin
        rst_n  = 1'b0;
        req_a  = 1'b0;
        req_b  = 1'b0;
        data_a = 4'h3;
        data_b = 4'hC;
        model_reset();
        #12;
        do_reset();

        // Single request from A, data visible on the bus.
        cycle(1'b1, 1'b0, 4'h5, 4'hA);
        chk("first_gnt_a", 32'(gnt_a), 1);
        chk("first_bus_y", 32'(bus_y), 32'h5);
        cycle(1'b0, 1'b0, 4'h6, 4'h9);

        // Tie right after reset goes to A, then direct hand-over to B.
        do_reset();
        cyc(1'b1, 1'b1);
        chk("tie_reset_a", 32'(gnt_a), 1);
        cyc(1'b0, 1'b1);
        chk("direct_b", 32'(gnt_b), 1);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        chk("idle_sel_held", 32'(sel), 1);
        cyc(1'b1, 1'b1);
        chk("tie_after_b", 32'(gnt_a), 1);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b1);
        chk("tie_after_a", 32'(gnt_b), 1);
        cyc(1'b0, 1'b0);

        // Forced hand-over after MAX_HOLD cycles in each direction.
        cyc(1'b1, 1'b0);
        run_len = gnt_a ? 1 : 0;
        for (int i = 0; i < 20 && !gnt_b; i++) begin
            cyc(1'b1, 1'b1);
            if (gnt_a) run_len++;
        end
        chk("hold_len_a", 32'(run_len), 32'(MAX_HOLD));
        chk("forced_b", 32'(gnt_b), 1);
        run_len = 1;
        for (int i = 0; i < 20 && !gnt_a; i++) begin
            cyc(1'b1, 1'b1);
            if (gnt_b) run_len++;
        end
        chk("hold_len_b", 32'(run_len), 32'(MAX_HOLD));
        cyc(1'b0, 1'b0);

        // Uncontested B is never released.
        drops = 0;
        for (int i = 0; i < 300; i++) begin
            cyc(1'b0, 1'b1);
            if (!gnt_b) drops++;
        end
        chk("b_no_release", 32'(drops), 0);
        chk("b_hold_sat", 32'(dut.hold_cnt), 32'(MAX_HOLD - 1));

        // Asynchronous reset mid-grant clears outputs without a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_gnt_b", 32'(gnt_b), 0);
        chk("async_sel", 32'(sel), 0);
        chk("async_valid", 32'(bus_valid), 0);
        model_reset();
        req_b = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, 1'b1);
        chk("post_rst_b", 32'(gnt_b), 1);

        // Random traffic against the model.
        for (int i = 0; i < 300; i++)
            cyc(1'($urandom), 1'($urandom));
        cyc(1'b0, 1'b0);

`ifdef ARB_STATS_EN
        do_reset();
        for (int i = 0; i < 130; i++) begin
            cyc(1'b1, 1'b0);
            cyc(1'b0, 1'b1);
        end
        chk("stats_alt_a", 32'(cnt_a), 130);
        chk("stats_alt_b", 32'(cnt_b), 130);
        cyc(1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 600; i++) begin
            cyc(1'b1, 1'b0);
            cyc(1'b0, 1'b0);
        end
        chk("stats_sat_a", 32'(cnt_a), 255);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
